// File: rtl/vga_render_pkg.sv
// Shared VGA timing constants, derived totals and the types used by the
// image renderer and its timing generator.
package vga_render_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int IMG_W  = 200;
  localparam int IMG_H  = 200;
  localparam int IMG_X0 = 220;
  localparam int IMG_Y0 = 140;
  localparam int ADDR_W = 16;
  localparam logic [7:0] BG_GRAY = 8'h00;

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START   = H_ACTIVE + H_FP;
  localparam int HS_END     = HS_START + H_SYNC;
  localparam int VS_START   = V_ACTIVE + V_FP;
  localparam int VS_END     = VS_START + V_SYNC;
  localparam int IMG_PIXELS = IMG_W * IMG_H;

  // Counter width covers every supported total up to 4095.
  localparam int CNT_W = 12;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {V_VIS, V_FRONT, V_SYNCP, V_BACK} vstate_t;

  // Per-pixel control bits that ride the pipeline alongside the fetch.
  typedef struct packed {
    logic hs;
    logic vs;
    logic bn;
    logic img;
    logic fs;
  } vctl_t;

  localparam vctl_t CTL_RESET = '{hs: 1'b1, vs: 1'b1, bn: 1'b0, img: 1'b0, fs: 1'b0};

endpackage

// File: rtl/vga_image_renderer_if.sv
// Framebuffer RAM read port B as seen by the renderer.
// rd_en qualifies rd_addr; pixel_data holds the word for that address one
// cycle later. There is no backpressure: the RAM must accept every fetch.
interface vga_image_renderer_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [31:0]       pixel_data;

  modport master (output rd_addr, output rd_en, input pixel_data);
  modport slave  (input rd_addr, input rd_en, output pixel_data);
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel/line counters, vertical-region FSM and raw (undelayed) sync,
// visible and frame-start decode.
module vga_timing_gen
  import vga_render_pkg::cnt_t, vga_render_pkg::vstate_t,
         vga_render_pkg::V_VIS, vga_render_pkg::V_FRONT,
         vga_render_pkg::V_SYNCP, vga_render_pkg::V_BACK;
#(
  parameter int H_ACTIVE = vga_render_pkg::H_ACTIVE,
  parameter int H_FP     = vga_render_pkg::H_FP,
  parameter int H_SYNC   = vga_render_pkg::H_SYNC,
  parameter int H_BP     = vga_render_pkg::H_BP,
  parameter int V_ACTIVE = vga_render_pkg::V_ACTIVE,
  parameter int V_FP     = vga_render_pkg::V_FP,
  parameter int V_SYNC   = vga_render_pkg::V_SYNC,
  parameter int V_BP     = vga_render_pkg::V_BP
) (
  input  logic    vga_clk,
  input  logic    reset,
  output cnt_t    h_cnt,
  output cnt_t    v_cnt,
  output vstate_t vstate,
  output logic    v_vis,
  output logic    visible,
  output logic    hsync_raw,
  output logic    vsync_raw,
  output logic    frame_start_raw
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VIS_END  = cnt_t'(H_ACTIVE);
  localparam cnt_t HS_LO      = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_HI      = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VIS_LAST   = cnt_t'(V_ACTIVE - 1);
  localparam cnt_t FRONT_LAST = cnt_t'(V_ACTIVE + V_FP - 1);
  localparam cnt_t SYNC_LAST  = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  cnt_t    h_cnt_q, h_cnt_d;
  cnt_t    v_cnt_q, v_cnt_d;
  vstate_t vstate_q, vstate_d;
  logic    line_wrap;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      vstate_q <= V_VIS;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      vstate_q <= vstate_d;
    end
  end

  // The vertical count and region only move on the last pixel of a line.
  always_comb begin
    line_wrap = (h_cnt_q == H_LAST);
    h_cnt_d   = line_wrap ? '0 : h_cnt_q + cnt_t'(1);
    v_cnt_d   = v_cnt_q;
    vstate_d  = vstate_q;
    if (line_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + cnt_t'(1);
      case (vstate_q)
        V_VIS:   if (v_cnt_q == VIS_LAST)   vstate_d = V_FRONT;
        V_FRONT: if (v_cnt_q == FRONT_LAST) vstate_d = V_SYNCP;
        V_SYNCP: if (v_cnt_q == SYNC_LAST)  vstate_d = V_BACK;
        V_BACK:  if (v_cnt_q == V_LAST)     vstate_d = V_VIS;
        default:                            vstate_d = V_VIS;
      endcase
    end
  end

  assign h_cnt           = h_cnt_q;
  assign v_cnt           = v_cnt_q;
  assign vstate          = vstate_q;
  assign v_vis           = (vstate_q == V_VIS);
  assign visible         = v_vis && (h_cnt_q < H_VIS_END);
  assign hsync_raw       = !((h_cnt_q >= HS_LO) && (h_cnt_q < HS_HI));
  assign vsync_raw       = (vstate_q != V_SYNCP);
  assign frame_start_raw = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_image_renderer.sv
// 640x480@60 VGA scan-out of a grey image window fetched from framebuffer
// port B, with a 3-stage pipeline keeping syncs aligned to colour.
module vga_image_renderer
  import vga_render_pkg::cnt_t, vga_render_pkg::vstate_t,
         vga_render_pkg::vctl_t, vga_render_pkg::CTL_RESET;
#(
  parameter int H_ACTIVE = vga_render_pkg::H_ACTIVE,
  parameter int H_FP     = vga_render_pkg::H_FP,
  parameter int H_SYNC   = vga_render_pkg::H_SYNC,
  parameter int H_BP     = vga_render_pkg::H_BP,
  parameter int V_ACTIVE = vga_render_pkg::V_ACTIVE,
  parameter int V_FP     = vga_render_pkg::V_FP,
  parameter int V_SYNC   = vga_render_pkg::V_SYNC,
  parameter int V_BP     = vga_render_pkg::V_BP,
  parameter int IMG_W    = vga_render_pkg::IMG_W,
  parameter int IMG_H    = vga_render_pkg::IMG_H,
  parameter int IMG_X0   = vga_render_pkg::IMG_X0,
  parameter int IMG_Y0   = vga_render_pkg::IMG_Y0,
  parameter int ADDR_W   = vga_render_pkg::ADDR_W,
  parameter logic [7:0] BG_GRAY = vga_render_pkg::BG_GRAY
) (
  input  logic                        vga_clk,
  input  logic                        reset,
  vga_image_renderer_if.master        ram,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        blank_n,
  output logic                        sync_n,
  output logic [7:0]                  vga_r,
  output logic [7:0]                  vga_g,
  output logic [7:0]                  vga_b,
  output logic                        frame_start,
  output vstate_t                     dbg_vstate
);

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t ADDR_LAST = addr_t'(IMG_W * IMG_H - 1);
  localparam cnt_t  X_LO      = cnt_t'(IMG_X0);
  localparam cnt_t  X_HI      = cnt_t'(IMG_X0 + IMG_W);
  localparam cnt_t  Y_LO      = cnt_t'(IMG_Y0);
  localparam cnt_t  Y_HI      = cnt_t'(IMG_Y0 + IMG_H);

  cnt_t h_cnt, v_cnt;
  logic v_vis, visible, hsync_raw, vsync_raw, frame_start_raw;
  logic in_img;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .vga_clk         (vga_clk),
    .reset           (reset),
    .h_cnt           (h_cnt),
    .v_cnt           (v_cnt),
    .vstate          (dbg_vstate),
    .v_vis           (v_vis),
    .visible         (visible),
    .hsync_raw       (hsync_raw),
    .vsync_raw       (vsync_raw),
    .frame_start_raw (frame_start_raw)
  );

  assign in_img = v_vis && (h_cnt >= X_LO) && (h_cnt < X_HI)
                        && (v_cnt >= Y_LO) && (v_cnt < Y_HI);

  addr_t rd_addr_q, rd_addr_d;
  addr_t addr_next_q, addr_next_d;
  addr_t fetch_base;
  logic  rd_en_q, rd_en_d;
  vctl_t ctl_raw;
  vctl_t ctl1_q, ctl1_d, ctl2_q, ctl2_d, ctl3_q, ctl3_d;
  logic [7:0] grey_q, grey_d;

  // Raster order makes the image linear, so a running count is the address.
  always_comb begin
    fetch_base  = frame_start_raw ? '0 : addr_next_q;
    rd_addr_d   = rd_addr_q;
    addr_next_d = addr_next_q;
    rd_en_d     = in_img;
    if (in_img) begin
      rd_addr_d   = fetch_base;
      addr_next_d = (fetch_base == ADDR_LAST) ? '0 : fetch_base + addr_t'(1);
    end else if (frame_start_raw) begin
      rd_addr_d   = '0;
      addr_next_d = '0;
    end
  end

  assign ctl_raw = '{hs: hsync_raw, vs: vsync_raw, bn: visible,
                     img: in_img, fs: frame_start_raw};

  // Stage 2 lines up with the RAM word; image bits imply visible.
  always_comb begin
    ctl1_d = ctl_raw;
    ctl2_d = ctl1_q;
    ctl3_d = ctl2_q;
    grey_d = 8'h00;
    if (ctl2_q.img)     grey_d = ram.pixel_data[7:0];
    else if (ctl2_q.bn) grey_d = BG_GRAY;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rd_addr_q   <= '0;
      addr_next_q <= '0;
      rd_en_q     <= 1'b0;
      ctl1_q      <= CTL_RESET;
      ctl2_q      <= CTL_RESET;
      ctl3_q      <= CTL_RESET;
      grey_q      <= 8'h00;
    end else begin
      rd_addr_q   <= rd_addr_d;
      addr_next_q <= addr_next_d;
      rd_en_q     <= rd_en_d;
      ctl1_q      <= ctl1_d;
      ctl2_q      <= ctl2_d;
      ctl3_q      <= ctl3_d;
      grey_q      <= grey_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ram.pixel_data[31:8], ctl3_q.img};

  assign ram.rd_addr = rd_addr_q;
  assign ram.rd_en   = rd_en_q;
  assign hsync       = ctl3_q.hs;
  assign vsync       = ctl3_q.vs;
  assign blank_n     = ctl3_q.bn;
  assign frame_start = ctl3_q.fs;
  assign sync_n      = 1'b0;
  assign vga_r       = grey_q;
  assign vga_g       = grey_q;
  assign vga_b       = grey_q;

endmodule

// File: tb/tb_vga_image_renderer.sv
// Bench for vga_image_renderer on a scaled-down raster so whole frames fit
// in a short run; a 1-cycle RAM returns the address byte as grey.
module tb_vga_image_renderer;

  localparam int HA = 40, HFP = 4, HSW = 6, HBP = 5;
  localparam int VA = 30, VFP = 2, VSW = 2, VBP = 3;
  localparam int IW = 10, IH = 8, IX0 = 12, IY0 = 9;
  localparam logic [7:0] BG = 8'h5A;
  localparam int HT   = HA + HFP + HSW + HBP;
  localparam int VT   = VA + VFP + VSW + VBP;
  localparam int FT   = HT * VT;
  localparam int NPIX = IW * IH;
  localparam int W    = 28;
  localparam logic [W-1:0] OUT_RST = {1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  logic hsync, vsync, blank_n, sync_n, frame_start;
  logic [7:0] vga_r, vga_g, vga_b;
  vga_render_pkg::vstate_t dbg_vstate;

  vga_image_renderer_if #(.ADDR_W(16)) ram_if ();

  vga_image_renderer #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .IMG_W (IW), .IMG_H (IH), .IMG_X0 (IX0), .IMG_Y0 (IY0),
    .ADDR_W (16), .BG_GRAY (BG)
  ) dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .ram         (ram_if),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .sync_n      (sync_n),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .frame_start (frame_start),
    .dbg_vstate  (dbg_vstate)
  );

  // Clock / reset and RAM model
  always #20 vga_clk = ~vga_clk;

  always @(posedge vga_clk)
    ram_if.pixel_data <= {24'($urandom_range(0, 32'hFFFFFF)), ram_if.rd_addr[7:0]};

  // Scoreboard state and statistics
  logic [W-1:0] exp_q[$];
  int errors = 0, checks = 0;
  int e_cnt = 0;
  int hs_low_cnt, vs_low_cnt, bn_cnt, rden_cnt, fs_cnt, max_addr;
  int hs_fall_e, fs_prev_e, fs_period;
  logic hs_prev;

  task automatic clear_stats();
    hs_low_cnt = 0; vs_low_cnt = 0; bn_cnt = 0; rden_cnt = 0;
    fs_cnt = 0; max_addr = 0; hs_fall_e = -1;
  endtask

  task automatic restart_model();
    e_cnt = 0;
    exp_q.delete();
    exp_q.push_back(OUT_RST);
    exp_q.push_back(OUT_RST);
    hs_prev = 1'b1;
    fs_prev_e = -1;
    fs_period = -1;
    clear_stats();
  endtask

  // One clock: check the fetch stage, push the expected output for that
  // pixel, and pop/compare the output that is due now.
  task automatic step();
    int p1, h, v, addr;
    logic img, hs, vs, bn, fs;
    logic [7:0] g;
    logic [W-1:0] exp_w, got_w;
    @(posedge vga_clk);
    #1;
    e_cnt++;
    p1   = (e_cnt - 1) % FT;
    h    = p1 % HT;
    v    = p1 / HT;
    img  = (h >= IX0) && (h < IX0 + IW) && (v >= IY0) && (v < IY0 + IH);
    addr = (v - IY0) * IW + (h - IX0);
    checks++;
    if (ram_if.rd_en !== img) begin
      errors++;
      $display("FAIL rd_en at h=%0d v=%0d: got %b want %b", h, v, ram_if.rd_en, img);
    end
    if (img) begin
      checks++;
      if (ram_if.rd_addr !== 16'(addr)) begin
        errors++;
        $display("FAIL rd_addr at h=%0d v=%0d: got %0d want %0d", h, v, ram_if.rd_addr, addr);
      end
    end
    checks++;
    if (ram_if.rd_addr > 16'(NPIX - 1) || sync_n !== 1'b0) begin
      errors++;
      $display("FAIL addr_range/sync_n: rd_addr %0d (max %0d) sync_n %b", ram_if.rd_addr, NPIX - 1, sync_n);
    end
    hs = !((h >= HA + HFP) && (h < HA + HFP + HSW));
    vs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
    bn = (h < HA) && (v < VA);
    fs = (p1 == 0);
    g  = img ? 8'(addr) : (bn ? BG : 8'h00);
    exp_q.push_back({fs, hs, vs, bn, g, g, g});
    if (exp_q.size() >= 3) begin
      exp_w = exp_q.pop_front();
      got_w = {frame_start, hsync, vsync, blank_n, vga_r, vga_g, vga_b};
      checks++;
      if (got_w !== exp_w) begin
        errors++;
        $display("FAIL video_out e=%0d {fs,hs,vs,bn,r,g,b}: got %h want %h", e_cnt, got_w, exp_w);
      end
    end
    if (!hsync) hs_low_cnt++;
    if (hs_prev && !hsync && hs_fall_e < 0) hs_fall_e = e_cnt;
    hs_prev = hsync;
    if (!vsync) vs_low_cnt++;
    if (blank_n) bn_cnt++;
    if (ram_if.rd_en) rden_cnt++;
    if (int'(ram_if.rd_addr) > max_addr) max_addr = int'(ram_if.rd_addr);
    if (frame_start) begin
      fs_cnt++;
      if (fs_prev_e >= 0) fs_period = e_cnt - fs_prev_e;
      fs_prev_e = e_cnt;
    end
  endtask

  // Step until the output shows frame-relative pixel index target.
  task automatic advance_to(input int target);
    int guard = 0;
    do begin
      step();
      guard++;
    end while ((((e_cnt - 3) % FT) + FT) % FT != target && guard < 2 * FT);
    if (guard >= 2 * FT) begin
      checks++;
      errors++;
      $display("FAIL advance_to timeout: target %0d not reached in %0d cycles", target, guard);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) begin
      @(posedge vga_clk);
      #1;
      checks++;
      if ({hsync, vsync, blank_n, frame_start} !== 4'b1100) begin
        errors++;
        $display("FAIL reset_syncs {hs,vs,bn,fs}: got %b want 1100", {hsync, vsync, blank_n, frame_start});
      end
      checks++;
      if (ram_if.rd_addr !== 16'd0 || ram_if.rd_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_fetch: rd_addr %0d rd_en %b want 0 0", ram_if.rd_addr, ram_if.rd_en);
      end
      checks++;
      if ({vga_r, vga_g, vga_b} !== 24'h0 || dbg_vstate !== vga_render_pkg::V_VIS) begin
        errors++;
        $display("FAIL reset_colour_state: rgb %h state %0d want 0 V_VIS", {vga_r, vga_g, vga_b}, dbg_vstate);
      end
    end
    reset = 1'b0;
    restart_model();
  endtask

  task automatic test_frame_start();
    logic found = 1'b0;
    while (!found && e_cnt < 10) begin
      step();
      if (frame_start) found = 1'b1;
    end
    checks++;
    if (!found || e_cnt != 3) begin
      errors++;
      $display("FAIL first_frame_start: seen %b at cycle %0d want cycle 3", found, e_cnt);
    end
  endtask

  task automatic test_line();
    int origin;
    advance_to(HT - 1);
    clear_stats();
    origin = e_cnt;
    repeat (HT) step();
    checks++;
    if (hs_low_cnt != HSW) begin
      errors++;
      $display("FAIL hsync_width: got %0d want %0d", hs_low_cnt, HSW);
    end
    checks++;
    if (hs_fall_e - origin - 1 != HA + HFP) begin
      errors++;
      $display("FAIL hsync_start: got %0d want %0d", hs_fall_e - origin - 1, HA + HFP);
    end
    checks++;
    if (bn_cnt != HA) begin
      errors++;
      $display("FAIL blank_n_per_line: got %0d want %0d", bn_cnt, HA);
    end
  endtask

  task automatic test_frame();
    advance_to(FT - 1);
    clear_stats();
    repeat (FT) step();
    checks++;
    if (vs_low_cnt != VSW * HT) begin
      errors++;
      $display("FAIL vsync_width: got %0d want %0d", vs_low_cnt, VSW * HT);
    end
    checks++;
    if (fs_cnt != 1 || fs_period != FT) begin
      errors++;
      $display("FAIL frame_period: pulses %0d period %0d want 1 %0d", fs_cnt, fs_period, FT);
    end
    checks++;
    if (rden_cnt != NPIX || max_addr != NPIX - 1) begin
      errors++;
      $display("FAIL fetch_count: rd_en %0d max %0d want %0d %0d", rden_cnt, max_addr, NPIX, NPIX - 1);
    end
    checks++;
    if (bn_cnt != HA * VA) begin
      errors++;
      $display("FAIL blank_n_per_frame: got %0d want %0d", bn_cnt, HA * VA);
    end
  endtask

  task automatic test_pixels();
    int tgt[4];
    logic [7:0] want[4];
    tgt[0] = IY0 * HT + IX0 - 1;       want[0] = BG;
    tgt[1] = IY0 * HT + IX0;           want[1] = 8'h00;
    tgt[2] = IY0 * HT + IX0 + 1;       want[2] = 8'h01;
    tgt[3] = (IY0 + 1) * HT + IX0;     want[3] = 8'(IW);
    for (int i = 0; i < 4; i++) begin
      advance_to(tgt[i]);
      checks++;
      if (vga_r !== want[i] || vga_g !== want[i] || vga_b !== want[i]) begin
        errors++;
        $display("FAIL pixel_%0d: rgb %h %h %h want %h", i, vga_r, vga_g, vga_b, want[i]);
      end
    end
  endtask

  task automatic test_addr_wrap();
    advance_to((IY0 + IH - 1) * HT + IX0 + IW - 1 - 2);
    checks++;
    if (ram_if.rd_addr !== 16'(NPIX - 1) || ram_if.rd_en !== 1'b1) begin
      errors++;
      $display("FAIL last_fetch: rd_addr %0d rd_en %b want %0d 1", ram_if.rd_addr, ram_if.rd_en, NPIX - 1);
    end
    advance_to(IY0 * HT + IX0 - 2);
    checks++;
    if (ram_if.rd_addr !== 16'd0 || ram_if.rd_en !== 1'b1) begin
      errors++;
      $display("FAIL next_frame_first_fetch: rd_addr %0d rd_en %b want 0 1", ram_if.rd_addr, ram_if.rd_en);
    end
  endtask

  task automatic test_mid_reset();
    advance_to(12 * HT + 15 - 3);
    reset = 1'b1;
    @(posedge vga_clk);
    #1;
    checks++;
    if ({hsync, vsync, blank_n, frame_start, ram_if.rd_en} !== 5'b11000 ||
        {vga_r, vga_g, vga_b} !== 24'h0 || ram_if.rd_addr !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: {hs,vs,bn,fs,en} %b rgb %h addr %0d want 11000 0 0",
               {hsync, vsync, blank_n, frame_start, ram_if.rd_en}, {vga_r, vga_g, vga_b}, ram_if.rd_addr);
    end
    checks++;
    if (dbg_vstate !== vga_render_pkg::V_VIS) begin
      errors++;
      $display("FAIL mid_reset_state: got %0d want V_VIS", dbg_vstate);
    end
    reset = 1'b0;
    restart_model();
    test_frame_start();
    test_frame();
  endtask

  initial begin
    restart_model();
    test_reset();
    test_frame_start();
    test_line();
    test_frame();
    test_pixels();
    test_addr_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
